// File: rtl/term_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : term_ctrl_pkg
// Description : Shared types and helpers for the terminal-condition
//               sequencing controller (state encoding, default counter
//               width, round-robin pointer advance).
// Revision    : 1.0 - initial release
// ============================================================================
package term_ctrl_pkg;

    // Default width of the step counter and of each requested burst length
    localparam int c_cnt_w_default = 5;

    // Controller states; the encoding is also driven out as the phase code
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Pointer that follows a given winner, wrapping modulo the requester count
    function automatic int rr_next_ptr(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage : term_ctrl_pkg
`default_nettype wire

// File: rtl/term_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : term_rr_arb
// Description : Combinational round-robin pick. Chooses the first asserted
//               request at or after the pointer, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module term_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from farthest to nearest offset so the nearest hit is written last
    always_comb begin
        int j;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N_REQ;
            if (i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(j);
                o_gnt   = N_REQ'(1) << j;
            end
        end
    end

endmodule : term_rr_arb
`default_nettype wire

// File: rtl/term_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : term_seq_ctrl
// Description : Sequencing controller for the terminal-condition datapath.
//               Round-robin arbitration, one qualified burst of step beats
//               per grant, registered phase/count feedback, completion and
//               abort reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module term_seq_ctrl
    import term_ctrl_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default,
    parameter int N_REQ = 2
) (
    input  logic                   clk_pad,
    input  logic                   rst_pad,
    input  logic [N_REQ-1:0]       req_pad,
    input  logic [N_REQ*CNT_W-1:0] len_pad,
    input  logic                   step_ok_pad,
    input  logic                   abort_pad,
    output logic [N_REQ-1:0]       gnt_pad,
    output logic [CNT_W-1:0]       cnt_pad,
    output logic [1:0]             phase_pad,
    output logic                   busy_pad,
    output logic                   done_pad,
    output logic                   aborted_pad
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_len;
    logic [N_REQ-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_aborted;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic [CNT_W-1:0]   w_len_sel;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last_beat;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_aborted_nxt;

    term_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (req_pad),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_len_sel   = len_pad[int'(w_arb_idx) * CNT_W +: CNT_W];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // Length is at least 1 whenever RUN is reached, so the count never wraps
    assign w_last_beat = (w_cnt_inc == r_len);

    // State register
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort takes precedence over a coinciding final beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (abort_pad || (r_len == '0)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_pad || (step_ok_pad && w_last_beat)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: values the output registers take at the next edge
    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = (w_state_nxt == ST_DONE);
        w_aborted_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = w_arb_valid ? w_arb_gnt : '0;
                w_cnt_nxt = '0;
            end
            ST_GRANT: begin
                w_aborted_nxt = abort_pad;
            end
            ST_RUN: begin
                w_aborted_nxt = abort_pad;
                if (!abort_pad && step_ok_pad) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_DONE: begin
                w_gnt_nxt = '0;
                w_cnt_nxt = '0;
            end
            default: begin
                w_gnt_nxt = '0;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Output registers plus burst context (winner, length, priority pointer)
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_ptr     <= '0;
            r_win     <= '0;
            r_len     <= '0;
        end else begin
            r_gnt     <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            if ((r_state == ST_IDLE) && w_arb_valid) begin
                r_win <= w_arb_idx;
                r_len <= w_len_sel;
            end
            if (r_state == ST_DONE) begin
                r_ptr <= IDX_W'(rr_next_ptr(int'(r_win), N_REQ));
            end
        end
    end

    assign gnt_pad     = r_gnt;
    assign cnt_pad     = r_cnt;
    assign phase_pad   = r_state;
    assign busy_pad    = (r_state != ST_IDLE);
    assign done_pad    = r_done;
    assign aborted_pad = r_aborted;

endmodule : term_seq_ctrl
`default_nettype wire

// File: tb/tb_term_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_term_seq_ctrl
// Description : Self-checking bench for term_seq_ctrl. A burst-level model
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_term_seq_ctrl;

    localparam int NR = 2;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*CW-1:0] len;
    logic            step_ok;
    logic            abort;
    logic [NR-1:0]   gnt;
    logic [CW-1:0]   cnt;
    logic [1:0]      phase;
    logic            busy;
    logic            done;
    logic            aborted;

    int n_checks = 0;
    int n_errors = 0;

    term_seq_ctrl #(.CNT_W(CW), .N_REQ(NR)) dut (
        .clk_pad     (clk),
        .rst_pad     (rst),
        .req_pad     (req),
        .len_pad     (len),
        .step_ok_pad (step_ok),
        .abort_pad   (abort),
        .gnt_pad     (gnt),
        .cnt_pad     (cnt),
        .phase_pad   (phase),
        .busy_pad    (busy),
        .done_pad    (done),
        .aborted_pad (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- burst-level model ----------------
    bit m_known = 0;
    bit m_active, m_first, m_ending, m_abort_end;
    int m_owner, m_len, m_beats, m_ptr;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1; m_active = 0; m_first = 0; m_ending = 0;
            m_abort_end = 0; m_owner = 0; m_len = 0; m_beats = 0; m_ptr = 0;
        end else if (!m_active) begin
            for (int k = NR - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % NR]) begin
                    m_owner = (m_ptr + k) % NR;
                    m_active = 1;
                end
            end
            if (m_active) begin
                m_len = int'(len[m_owner*CW +: CW]);
                m_first = 1; m_ending = 0; m_abort_end = 0; m_beats = 0;
            end
        end else if (m_first) begin
            m_first = 0;
            if (abort) begin
                m_ending = 1; m_abort_end = 1;
            end else if (m_len == 0) begin
                m_ending = 1;
            end
        end else if (m_ending) begin
            m_active = 0; m_ending = 0; m_beats = 0;
            m_ptr = (m_owner + 1) % NR;
        end else begin
            if (abort) begin
                m_ending = 1; m_abort_end = 1;
            end else if (step_ok) begin
                m_beats++;
                if (m_beats == m_len) m_ending = 1;
            end
        end
    end

    // Compare DUT against the model on every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_known) begin
            chk("m_gnt", int'(gnt), m_active ? (1 << m_owner) : 0);
            chk("m_cnt", int'(cnt), m_beats);
            chk("m_phase", int'(phase), !m_active ? 0 : m_first ? 1 : m_ending ? 3 : 2);
            chk("m_busy", int'(busy), int'(m_active));
            chk("m_done", int'(done), int'(m_ending));
            chk("m_aborted", int'(aborted), int'(m_ending && m_abort_end));
        end
    end

    // ---------------- directed stimulus ----------------
    int t1_ph [6] = '{1, 2, 2, 2, 3, 0};
    int t1_cnt[6] = '{0, 0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req = '0; len = '0; step_ok = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_phase", int'(phase), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        rst = 1'b0;

        // Single burst, len 3, qualifier always high
        req = 2'b01; len[0 +: CW] = 5'd3; step_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_phase", int'(phase), t1_ph[i]);
            chk("t1_cnt", int'(cnt), t1_cnt[i]);
            if (i == 0) begin
                chk("t1_gnt", int'(gnt), 1);
                req = 2'b00;
            end
            if (i == 4) begin
                chk("t1_done", int'(done), 1);
                chk("t1_aborted", int'(aborted), 0);
            end
        end

        // Both requesting after a fresh reset: grants alternate 01,10,...
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 2'b11; len = {5'd1, 5'd1};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i % 4 == 0) begin
                chk("t2_phase", int'(phase), 1);
                chk("t2_gnt", int'(gnt), ((i / 4) % 2 == 0) ? 1 : 2);
            end
            if (i == 14) req = 2'b00;
        end

        // len 5 with a toggling qualifier
        req = 2'b01; len[0 +: CW] = 5'd5; step_ok = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            step_ok = (i % 2 == 0);
            if (i == 0) req = 2'b00;
            if (i == 4) chk("t3_hold_cnt", int'(cnt), 1);
            if (i == 11) begin
                chk("t3_phase", int'(phase), 3);
                chk("t3_cnt", int'(cnt), 5);
                chk("t3_done", int'(done), 1);
            end
            if (i == 12) chk("t3_idle", int'(phase), 0);
        end

        // Zero-length burst on requester 1
        req = 2'b10; len[CW +: CW] = 5'd0; step_ok = 1'b0;
        @(negedge clk);
        chk("t4_gnt", int'(gnt), 2);
        chk("t4_phase", int'(phase), 1);
        req = 2'b00;
        @(negedge clk);
        chk("t4_phase_done", int'(phase), 3);
        chk("t4_done", int'(done), 1);
        chk("t4_cnt", int'(cnt), 0);
        @(negedge clk);
        chk("t4_idle", int'(phase), 0);

        // len 31, abort coincides with a qualified beat at count 7
        req = 2'b01; len[0 +: CW] = 5'd31; step_ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) req = 2'b00;
            if (i == 8) begin
                chk("t5_pre_cnt", int'(cnt), 7);
                abort = 1'b1;
            end
            if (i == 9) begin
                chk("t5_phase", int'(phase), 3);
                chk("t5_cnt", int'(cnt), 7);
                chk("t5_aborted", int'(aborted), 1);
                chk("t5_done", int'(done), 1);
                abort = 1'b0;
            end
        end

        // Pointer moved past requester 0: requester 1 wins a tie
        req = 2'b11; len = {5'd2, 5'd2};
        @(negedge clk);
        chk("t5_ptr_gnt", int'(gnt), 2);
        req = 2'b00;
        repeat (4) @(negedge clk);

        // Reset in RUN at count 4 on requester 1
        req = 2'b10; len[CW +: CW] = 5'd31; step_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("t6_pre_cnt", int'(cnt), 4);
                chk("t6_pre_phase", int'(phase), 2);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        chk("t6_rst_phase", int'(phase), 0);
        chk("t6_rst_gnt", int'(gnt), 0);
        chk("t6_rst_cnt", int'(cnt), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_busy", int'(busy), 0);
        rst = 1'b0; req = 2'b11; len[0 +: CW] = 5'd1;
        @(negedge clk);
        chk("t6_prio_gnt", int'(gnt), 1);
        req = 2'b00;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_term_seq_ctrl
`default_nettype wire
